// File: rtl/gray_to_lcd_tx_if.sv
// Transmit-side video bundle: upstream FIFO read port plus panel RGB, sync and coordinate outputs.
// The master modport is the timing generator; the slave side is the FIFO and panel.
interface gray_to_lcd_tx_if;
  logic        fifo_empty;
  logic [7:0]  gray_in;
  logic        rd_en;
  logic        hs;
  logic        vs;
  logic        data_de;
  logic [7:0]  data_r;
  logic [7:0]  data_g;
  logic [7:0]  data_b;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        frame_start;
  logic        underflow;

  modport master (
    input  fifo_empty, gray_in,
    output rd_en, hs, vs, data_de, data_r, data_g, data_b, pix_x, pix_y, frame_start, underflow
  );

  modport slave (
    output fifo_empty, gray_in,
    input  rd_en, hs, vs, data_de, data_r, data_g, data_b, pix_x, pix_y, frame_start, underflow
  );
endinterface

// File: rtl/gray_to_lcd_tx.sv
// Panel timing generator that reads one gray sample per active pixel and drives it as R=G=B.
// Optional TEST_PATTERN_EN adds a test_mode input that replaces FIFO data with a horizontal ramp.
module gray_to_lcd_tx #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 48,
  parameter int unsigned H_SYNC   = 32,
  parameter int unsigned H_BP     = 80,
  parameter int unsigned V_ACTIVE = 800,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 14,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic             i_pix_clk,
  input  logic             rst_n,
`ifdef TEST_PATTERN_EN
  input  logic             test_mode,
`endif
  gray_to_lcd_tx_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        act, in_hsync, in_vsync, tp;

  // Stage 1: raster state aligned with the FIFO read data
  logic        act_q, miss_q, tp_q, hs_s1_q, vs_s1_q, fs_s1_q;
  logic [10:0] x_s1_q, y_s1_q;

  // Stage 2: output registers
  logic        de_q, hs_q, vs_q, fs_q, uf_q;
  logic [7:0]  pix_q, pix_d;
  logic [10:0] x_q, y_q;

`ifdef TEST_PATTERN_EN
  assign tp = test_mode;
`else
  assign tp = 1'b0;
`endif

  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
    end
  end

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign act      = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
  assign in_hsync = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
  assign in_vsync = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);

  // A missing sample is skipped rather than stalled, so the raster never slips
  assign bus.rd_en = act && !bus.fifo_empty && !tp;

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q   <= 1'b0;
      miss_q  <= 1'b0;
      tp_q    <= 1'b0;
      hs_s1_q <= ~SYNC_POL;
      vs_s1_q <= ~SYNC_POL;
      fs_s1_q <= 1'b0;
      x_s1_q  <= '0;
      y_s1_q  <= '0;
    end else begin
      act_q   <= act;
      miss_q  <= act && bus.fifo_empty && !tp;
      tp_q    <= tp;
      hs_s1_q <= in_hsync ? SYNC_POL : ~SYNC_POL;
      vs_s1_q <= in_vsync ? SYNC_POL : ~SYNC_POL;
      fs_s1_q <= act && (h_cnt_q == '0) && (v_cnt_q == '0);
      x_s1_q  <= act ? h_cnt_q + 11'd1 : '0;
      y_s1_q  <= act ? v_cnt_q + 11'd1 : '0;
    end
  end

  always_comb begin
    pix_d = 8'h00;
    if (act_q) begin
      if (tp_q) begin
        pix_d = x_s1_q[7:0] - 8'd1;
      end else if (!miss_q) begin
        pix_d = bus.gray_in;
      end
    end
  end

  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q  <= 1'b0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      fs_q  <= 1'b0;
      uf_q  <= 1'b0;
      pix_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      de_q  <= act_q;
      hs_q  <= hs_s1_q;
      vs_q  <= vs_s1_q;
      fs_q  <= fs_s1_q;
      uf_q  <= miss_q;
      pix_q <= pix_d;
      x_q   <= x_s1_q;
      y_q   <= y_s1_q;
    end
  end

  assign bus.data_de     = de_q;
  assign bus.hs          = hs_q;
  assign bus.vs          = vs_q;
  assign bus.data_r      = pix_q;
  assign bus.data_g      = pix_q;
  assign bus.data_b      = pix_q;
  assign bus.pix_x       = x_q;
  assign bus.pix_y       = y_q;
  assign bus.frame_start = fs_q;
  assign bus.underflow   = uf_q;

endmodule

// File: tb/tb_gray_to_lcd_tx.sv
// Directed bench for gray_to_lcd_tx on a shrunken 25x10 raster (16x6 active).
// Checkpoint table plus frame totals, FIFO underflow, loopback and mid-frame reset sequences.
module tb_gray_to_lcd_tx;
  localparam int unsigned HA = 16, HF = 3, HS = 2, HB = 4;
  localparam int unsigned VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int FRAME = 250;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  gray_to_lcd_tx_if bus ();

  gray_to_lcd_tx #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (1'b0)
  ) dut (
    .i_pix_clk (clk),
    .rst_n     (rst_n),
`ifdef TEST_PATTERN_EN
    .test_mode (1'b0),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          s;  // raster state cycle; outputs expected at s+2
    logic        de, hs, vs;
    logic [10:0] x, y;
    logic [7:0]  d;
    logic        fs, uf;
  } vec_t;

  vec_t       vecs[$];
  int         n_vec = 0, n_bad = 0;
  int         cyc, vp, rd_count;
  int         empty_lo = -1, empty_hi = -2;
  bit         agg_en = 1'b0;
  int         de_n[2], hsl_n[2], vsl_n[2], fs_n[2], uf_n[2], rd_n[2];
  int         blank_bad = 0, rd_empty_bad = 0, sb_pops = 0;
  logic [7:0] sbq[$];
  logic [7:0] loop_vals [4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input int s, input int de, hs, vs, x, y, d, fs, uf);
    vec_t v;
    v.s = s; v.de = de[0]; v.hs = hs[0]; v.vs = vs[0];
    v.x = 11'(x); v.y = 11'(y); v.d = 8'(d); v.fs = fs[0]; v.uf = uf[0];
    vecs.push_back(v);
  endtask

  task automatic reset_checks(input string p);
    chk({p, ".de"}, 32'(bus.data_de), 32'd0);
    chk({p, ".hs"}, 32'(bus.hs), 32'd1);
    chk({p, ".vs"}, 32'(bus.vs), 32'd1);
    chk({p, ".x"}, 32'(bus.pix_x), 32'd0);
    chk({p, ".y"}, 32'(bus.pix_y), 32'd0);
    chk({p, ".rgb"}, {8'd0, bus.data_r, bus.data_g, bus.data_b}, 32'd0);
    chk({p, ".fs"}, 32'(bus.frame_start), 32'd0);
    chk({p, ".uf"}, 32'(bus.underflow), 32'd0);
  endtask

  // One pixel clock, entered and left at a falling edge.
  task automatic tick();
    logic rd;
    int   f;
    while (vp < vecs.size() && vecs[vp].s + 2 == cyc) begin
      string p;
      p = $sformatf("vec%0d", vp);
      chk({p, ".de"}, 32'(bus.data_de), 32'(vecs[vp].de));
      chk({p, ".hs"}, 32'(bus.hs), 32'(vecs[vp].hs));
      chk({p, ".vs"}, 32'(bus.vs), 32'(vecs[vp].vs));
      chk({p, ".x"}, 32'(bus.pix_x), 32'(vecs[vp].x));
      chk({p, ".y"}, 32'(bus.pix_y), 32'(vecs[vp].y));
      chk({p, ".r"}, 32'(bus.data_r), 32'(vecs[vp].d));
      chk({p, ".g"}, 32'(bus.data_g), 32'(vecs[vp].d));
      chk({p, ".b"}, 32'(bus.data_b), 32'(vecs[vp].d));
      chk({p, ".fs"}, 32'(bus.frame_start), 32'(vecs[vp].fs));
      chk({p, ".uf"}, 32'(bus.underflow), 32'(vecs[vp].uf));
      vp++;
    end
    if (cyc == 1) chk("de_before_latency", 32'(bus.data_de), 32'd0);
    if (!bus.data_de && (bus.pix_x != 0 || bus.pix_y != 0)) blank_bad++;
    if (bus.data_de && (bus.pix_x < 1 || bus.pix_x > 11'(HA) || bus.pix_y < 1 ||
                        bus.pix_y > 11'(VA))) blank_bad++;
    if (agg_en && cyc >= 2 && cyc < 2 + 2 * FRAME) begin
      f = (cyc - 2) / FRAME;
      de_n[f]  += int'(bus.data_de);
      hsl_n[f] += int'(!bus.hs);
      vsl_n[f] += int'(!bus.vs);
      fs_n[f]  += int'(bus.frame_start);
      uf_n[f]  += int'(bus.underflow);
    end
    // Loopback: capture side recovers gray as the channel average
    if (agg_en && cyc >= 2 * FRAME + 2 && cyc < 3 * FRAME + 2 && bus.data_de) begin
      if (sbq.size() == 0) begin
        chk("loopback_underrun", 32'(sbq.size()), 32'd1);
      end else begin
        chk($sformatf("loopback@%0d", cyc),
            32'((int'(bus.data_r) + int'(bus.data_g) + int'(bus.data_b)) / 3),
            32'(sbq.pop_front()));
        sb_pops++;
      end
    end

    bus.fifo_empty = (cyc >= empty_lo && cyc <= empty_hi);
    #1;
    rd = bus.rd_en;
    if (rd && bus.fifo_empty) rd_empty_bad++;
    if (agg_en && cyc < 2 * FRAME) rd_n[cyc / FRAME] += int'(rd);
    if (cyc == 0) chk("rd_en_first", 32'(rd), 32'd1);
    if (agg_en && cyc >= 259 && cyc <= 263)
      chk($sformatf("rd_en@%0d", cyc), 32'(rd), 32'(cyc == 259 || cyc == 263));

    @(posedge clk);
    #1;
    if (rd) begin
      if (agg_en && cyc >= 2 * FRAME && cyc < 3 * FRAME) begin
        bus.gray_in = loop_vals[rd_count % 4];
        sbq.push_back(bus.gray_in);
      end else begin
        bus.gray_in = 8'(rd_count);
      end
      rd_count++;
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    loop_vals = '{8'd0, 8'd37, 8'd128, 8'd255};
    for (int i = 0; i < 2; i++) begin
      de_n[i] = 0; hsl_n[i] = 0; vsl_n[i] = 0; fs_n[i] = 0; uf_n[i] = 0; rd_n[i] = 0;
    end
    //   s    de hs vs  x   y   d   fs uf
    add(0,    1, 1, 1,  1,  1,  0,  1, 0);
    add(1,    1, 1, 1,  2,  1,  1,  0, 0);
    add(15,   1, 1, 1, 16,  1, 15,  0, 0);
    add(16,   0, 1, 1,  0,  0,  0,  0, 0);
    add(18,   0, 1, 1,  0,  0,  0,  0, 0);
    add(19,   0, 0, 1,  0,  0,  0,  0, 0);
    add(20,   0, 0, 1,  0,  0,  0,  0, 0);
    add(21,   0, 1, 1,  0,  0,  0,  0, 0);
    add(25,   1, 1, 1,  1,  2, 16,  0, 0);
    add(140,  1, 1, 1, 16,  6, 95,  0, 0);
    add(150,  0, 1, 1,  0,  0,  0,  0, 0);
    add(175,  0, 1, 0,  0,  0,  0,  0, 0);
    add(219,  0, 0, 0,  0,  0,  0,  0, 0);
    add(225,  0, 1, 1,  0,  0,  0,  0, 0);
    add(249,  0, 1, 1,  0,  0,  0,  0, 0);
    add(250,  1, 1, 1,  1,  1, 96,  1, 0);
    add(259,  1, 1, 1, 10,  1, 105, 0, 0);
    add(260,  1, 1, 1, 11,  1,  0,  0, 1);
    add(261,  1, 1, 1, 12,  1,  0,  0, 1);
    add(262,  1, 1, 1, 13,  1,  0,  0, 1);
    add(263,  1, 1, 1, 14,  1, 106, 0, 0);
    add(265,  1, 1, 1, 16,  1, 108, 0, 0);
    add(275,  1, 1, 1,  1,  2, 109, 0, 0);

    bus.fifo_empty = 1'b1;
    bus.gray_in    = 8'h00;
    repeat (3) @(negedge clk);
    reset_checks("por");

    rst_n = 1'b1;
    cyc = 0; vp = 0; rd_count = 0; agg_en = 1'b1;
    empty_lo = 260; empty_hi = 262;
    repeat (3 * FRAME + 82) tick();

    // Reset lands at frame 3, line 3 while pixels are in flight
    agg_en = 1'b0;
    rst_n = 1'b0;
    bus.fifo_empty = 1'b1;
    #1;
    chk("async_reset_de", 32'(bus.data_de), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_checks("mid");

    rst_n = 1'b1;
    cyc = 0; vp = 0; rd_count = 0; empty_lo = -1; empty_hi = -2;
    repeat (30) tick();

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("frame%0d.de_clocks", i), 32'(de_n[i]), 32'(HA * VA));
      chk($sformatf("frame%0d.hs_low", i), 32'(hsl_n[i]), 32'(HS * 10));
      chk($sformatf("frame%0d.vs_low", i), 32'(vsl_n[i]), 32'(VS * 25));
      chk($sformatf("frame%0d.frame_start", i), 32'(fs_n[i]), 32'd1);
      chk($sformatf("frame%0d.underflow", i), 32'(uf_n[i]), (i == 0) ? 32'd0 : 32'd3);
      chk($sformatf("frame%0d.reads", i), 32'(rd_n[i]), (i == 0) ? 32'd96 : 32'd93);
    end
    chk("loopback_pixels", 32'(sb_pops), 32'd96);
    chk("coord_outside_de", 32'(blank_bad), 32'd0);
    chk("rd_en_while_empty", 32'(rd_empty_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_to_lcd_tx.md
# gray_to_lcd_tx

Video transmit block for the MiniLED path. It generates 1280×800 panel timing on the pixel clock and pulls one 8-bit gray sample per active pixel from the upstream frame-buffer read FIFO. It drives each sample out as equal R/G/B together with HS/VS/DE and 1-based pixel coordinates. It is the transmit-side counterpart of the gray converter on the capture side: its data_de/data_r/g/b/pix_x/pix_y use the same conventions, so feeding its output back into the capture path returns the original gray values.

## Interface
- H_ACTIVE, 1280, active pixels per line
- H_FP, 48, horizontal front porch (clocks)
- H_SYNC, 32, HS pulse width (clocks)
- H_BP, 80, horizontal back porch (clocks)
- V_ACTIVE, 800, active lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, VS pulse width (lines)
- V_BP, 14, vertical back porch (lines)
- SYNC_POL, 1'b0, asserted level of hs/vs
- i_pix_clk  in  1  pixel clock; the only clock in the block
- rst_n  in  1  reset, asynchronous assert, active-low
- fifo_empty  in  1  upstream read FIFO empty
- gray_in  in  8  FIFO read data, valid the cycle after rd_en
- rd_en  out  1  FIFO read strobe
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- data_de  out  1  active-pixel enable
- data_r / data_g / data_b  out  8 each  pixel data
- pix_x  out  11  column 1..1280 while data_de is high, 0 otherwise
- pix_y  out  11  line 1..800 while data_de is high, 0 otherwise
- frame_start  out  1  one-clock pulse coincident with pixel (1,1)
- underflow  out  1  one-clock pulse on a pixel that had no FIFO data

## Operation
- **Counters**
  - h_cnt runs 0..H_TOTAL-1, with H_TOTAL = sum of the H_* parameters (1440 by default).
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1 (823 by default).
  - Both wrap to 0 together at the end of the frame.
- **Line layout**: active (h_cnt < H_ACTIVE), then FP, then SYNC, then BP. Frame layout is the same order in lines.
- **Sync**: hs = SYNC_POL while h_cnt is in the SYNC region; vs = SYNC_POL for the whole of each SYNC line. Otherwise both are ~SYNC_POL.
- **Read request**: act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE). rd_en = act && !fifo_empty is combinational from the registers and fifo_empty.
- **Pixel stage**: act, the miss flag (act && fifo_empty) and the coordinates are registered once, so they line up with gray_in.
- **Output stage (registered)**:
  - data_de = act.
  - data_r = data_g = data_b = gray_in on a hit, or 8'h00 on a miss.
  - underflow = miss.
  - pix_x = h_cnt+1 and pix_y = v_cnt+1 when active; both 0 otherwise.
  - frame_start = act at coordinate (1,1).
- On underflow the timing does not stall. The pixel goes out black and no read is issued, so a late FIFO shifts the data but never the raster.
- Arithmetic: counters are 11 bits, and all compares are unsigned against the parameter sums.

## Timing
- **Reset values**: all data, coordinate, de, frame_start and underflow outputs are 0; hs = vs = ~SYNC_POL; h_cnt = v_cnt = 0. rd_en may assert in the first cycle after reset release.
- **Latency**: the counter state at cycle n appears on the outputs at cycle n+2. hs, vs, data_de, pix_x/pix_y, data and flags all pass through the same 2-stage delay, so they are mutually aligned.
- **FIFO contract**: read latency is 1 clock. rd_en is never asserted while fifo_empty = 1.
- **Reset mid-frame**: the raster restarts at (0,0) and any in-flight pixels are discarded. No FIFO flush is issued; the upstream block owns flushing.
- A fifo_empty glitch on a single active cycle affects exactly that one pixel.

## Configuration
- **TEST_PATTERN_EN**: when defined, an extra input `test_mode` (1 bit) is added.
  - With test_mode = 1: rd_en is forced to 0 and underflow is held at 0.
  - Output data = pix_x[7:0] - 1, giving a repeating horizontal ramp 0..255.
  - Timing is unchanged.
- When TEST_PATTERN_EN is undefined, the port and the logic are absent and behaviour is as described above.

## Test plan
- **Reset and raster**: FIFO never empty, gray_in = 8'hA5, run 2 frames.
  - Expect 1440 clocks per line and 823 lines per frame.
  - Expect 1280 de clocks per line with data 0xA5 on all channels.
  - hs is low for 32 clocks starting 48 clocks after de falls; vs is low for 6 lines.
- **Coordinates**: expect pix_x 1..1280 and pix_y 1..800 while de is high, and 0 in blanking. frame_start fires once per frame, at the same clock as the first de.
- **Latency**: gray_in returns a per-read incrementing count.
  - The first output pixel is 0.
  - data_de rises exactly 2 clocks after the first rd_en.
  - The count reaches 1280×800 - 1 at pixel (1280,800).
- **Underflow**: fifo_empty = 1 for active pixels 10..12 of line 1.
  - Expect no rd_en in those cycles and data 0 at pix_x 11..13.
  - Expect underflow pulses on the same three clocks; hs/vs/de are unaffected.
- **Loopback**: drive outputs into the capture-side gray converter with gray_in = 0, 37, 128, 255. The recovered gray must equal gray_in.
- **Mid-frame reset**: assert rst_n low at line 400 for 5 clocks. All outputs must hold their reset values, and after release the first de begins at (1,1) 2 clocks after the first rd_en.
